// File: rtl/midi_if.sv
// midi_if: byte input, channel select and decoded event outputs of the MIDI parser
interface midi_if;
  logic        ce;
  logic        dv;
  logic [7:0]  di;
  logic [3:0]  ch;
  logic        note_on;
  logic        note_off;
  logic        cc_v;
  logic        pb_v;
  logic [3:0]  msg_ch;
  logic [6:0]  d1;
  logic [6:0]  d2;
  logic [13:0] pb;
  modport master (output ce, dv, di, ch, input note_on, note_off, cc_v, pb_v, msg_ch, d1, d2, pb);
  modport slave  (input ce, dv, di, ch, output note_on, note_off, cc_v, pb_v, msg_ch, d1, d2, pb);
endinterface

// File: rtl/midi_parser.sv
// midi_parser: running-status MIDI decoder emitting note/CC/pitch-bend strobes with registered fields
module midi_parser #(
  parameter bit OMNI = 1'b0
) (
  input logic   clk,
  input logic   rst,
  midi_if.slave m
);
  typedef enum logic [1:0] {WAIT, D1, D2} state_t;
  state_t     state;
  logic [7:0] rs;
  logic       rs_ok;
  logic [6:0] b1;
  logic       take, data, chs, sys, two, done, hit, nz, on, off, cc, pbv, emit;
  logic [3:0] typ;
  // byte classification and completion decode for the byte being consumed
  always_comb begin
    take = m.ce && m.dv;
    data = !m.di[7];
    chs  = m.di[7] && (m.di[7:4] != 4'hF);
    sys  = m.di[7:3] == 5'b11110;
    typ  = rs[7:4];
    two  = (typ != 4'hC) && (typ != 4'hD);
    done = take && data && rs_ok && (state == D2);
    hit  = OMNI || (rs[3:0] == m.ch);
    nz   = m.di[6:0] != 7'd0;
    on   = done && hit && (typ == 4'h9) && nz;
    off  = done && hit && ((typ == 4'h8) || ((typ == 4'h9) && !nz));
    cc   = done && hit && (typ == 4'hB);
    pbv  = done && hit && (typ == 4'hE);
    emit = on || off || cc || pbv;
  end
  // parser FSM with registered strobes and event fields; real-time bytes fall through untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT;
      rs         <= 8'h00;
      rs_ok      <= 1'b0;
      b1         <= 7'd0;
      m.note_on  <= 1'b0;
      m.note_off <= 1'b0;
      m.cc_v     <= 1'b0;
      m.pb_v     <= 1'b0;
      m.msg_ch   <= 4'd0;
      m.d1       <= 7'd0;
      m.d2       <= 7'd0;
      m.pb       <= 14'h2000;
    end else begin
      m.note_on  <= on;
      m.note_off <= off;
      m.cc_v     <= cc;
      m.pb_v     <= pbv;
      if (emit) begin
        m.msg_ch <= rs[3:0];
        m.d1     <= b1;
        m.d2     <= m.di[6:0];
        m.pb     <= {m.di[6:0], b1};
      end
      if (take) begin
        if (chs) begin
          rs    <= m.di;
          rs_ok <= 1'b1;
          state <= D1;
        end else if (sys) begin
          rs_ok <= 1'b0;
          state <= WAIT;
        end else if (data && rs_ok) begin
          if (state == D1) begin
            b1    <= m.di[6:0];
            state <= two ? D2 : D1;
          end else if (state == D2) begin
            state <= D1;
          end
        end
      end
    end
  end
endmodule
